up_counter_cle: RTL



---
 rtl/up_counter_cle.sv | 58 +++++
 1 files changed

// File: rtl/up_counter_cle.sv
// up_counter_cle: modulo-MOD incrementing counter with asynchronous clear, synchronous
// load, count enable, combinational cascade carry and a sticky wrap flag.
module up_counter_cle #(
   parameter int M   = 4,
   parameter int MOD = 2 ** M
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ce,
   input  logic         l,
   input  logic [M-1:0] di,
   input  logic         wclr,
   output logic [M-1:0] Q,
   output logic         TC,
   output logic         CEO,
   output logic         WRAP
);

   localparam int           LAST_I = MOD - 1;
   localparam logic [M-1:0] LAST   = LAST_I[M-1:0];
   localparam logic [M:0]   MOD_W  = MOD[M:0];

   // Loads outside 0..MOD-1 fold to zero so Q always stays inside the sequence.
   function automatic logic [M-1:0] fold_load(input logic [M-1:0] v);
      return (v <= LAST) ? v : '0;
   endfunction

   logic [M:0]   q_inc;
   logic [M-1:0] q_nxt;
   logic         wrap_evt;
   logic         wrap_nxt;

   assign TC  = (Q == LAST);
   assign CEO = ce & TC;

   // Increment carries one extra bit so that MOD = 2^M compares cleanly.
   always_comb begin
      q_inc    = {1'b0, Q} + {{M{1'b0}}, 1'b1};
      wrap_evt = ce & ~l & TC;
      q_nxt    = Q;
      if (l)
         q_nxt = fold_load(di);
      else if (ce)
         q_nxt = (q_inc == MOD_W) ? '0 : q_inc[M-1:0];
      wrap_nxt = wrap_evt | (WRAP & ~wclr);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         Q    <= '0;
         WRAP <= 1'b0;
      end else begin
         Q    <= q_nxt;
         WRAP <= wrap_nxt;
      end
   end

endmodule
